// File: rtl/imm_enc_if.sv
// Stream interface for imm_encoder: immediate/template input side and encoded-instruction output
// side. The encoder uses the slave modport; the producer/consumer uses master.
interface imm_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imm;
  logic [1:0]  imm_src;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        range_err;

  modport master (
    output in_valid, imm, imm_src, base_instr, out_ready,
    input  in_ready, out_valid, instr, range_err
  );

  modport slave (
    input  in_valid, imm, imm_src, base_instr, out_ready,
    output in_ready, out_valid, instr, range_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a signed immediate into the RISC-V I/S/B/J fields of a template word; 2-stage pipeline.
// Define IMM_RANGE_CHECK_EN to enable the representability check, range_err and err_count.
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_enc_if.slave         bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic        s1_valid_q;
  logic [20:0] s1_imm_q;
  logic [1:0]  s1_src_q;
  logic [31:0] s1_base_q;
  logic        out_valid_q;
  logic [31:0] instr_q;
  logic [31:0] merged;
  logic        s1_adv, s2_adv, out_fire;
  logic [CNT_W-1:0] enc_cnt_q;

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;
  assign out_fire     = out_valid_q && bus.out_ready;

  always_comb begin
    merged = s1_base_q;
    case (s1_src_q)
      2'b00: merged = {s1_imm_q[11:0], s1_base_q[19:0]};
      2'b01: merged = {s1_imm_q[11:5], s1_base_q[24:12], s1_imm_q[4:0], s1_base_q[6:0]};
      2'b10: merged = {s1_imm_q[12], s1_imm_q[10:5], s1_base_q[24:12], s1_imm_q[4:1],
                       s1_imm_q[11], s1_base_q[6:0]};
      default: merged = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                         s1_base_q[11:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_imm_q    <= '0;
      s1_src_q    <= 2'b00;
      s1_base_q   <= '0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_imm_q  <= bus.imm[20:0];
          s1_src_q  <= bus.imm_src;
          s1_base_q <= bus.base_instr;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) instr_q <= merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt_q <= '0;
    end else if (out_fire && enc_cnt_q != CntMax) begin
      enc_cnt_q <= enc_cnt_q + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.instr     = instr_q;
  assign enc_count     = enc_cnt_q;

`ifdef IMM_RANGE_CHECK_EN
  logic             in_err;
  logic             s1_err_q;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt_q;

  // Representable iff the bits above the field's sign bit are a pure sign extension.
  always_comb begin
    in_err = 1'b0;
    case (bus.imm_src)
      2'b00, 2'b01: in_err = !(&bus.imm[31:11] || ~|bus.imm[31:11]);
      2'b10:        in_err = !(&bus.imm[31:12] || ~|bus.imm[31:12]) || bus.imm[0];
      default:      in_err = !(&bus.imm[31:20] || ~|bus.imm[31:20]) || bus.imm[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (s1_adv && bus.in_valid) s1_err_q <= in_err;
      if (s2_adv && s1_valid_q)   err_q    <= s1_err_q;
      if (out_fire && err_q && err_cnt_q != CntMax) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.range_err = err_q;
  assign err_count     = err_cnt_q;
`else
  // Upper immediate bits only feed the range check.
  logic unused_imm_hi;
  assign unused_imm_hi = ^bus.imm[31:21];
  assign bus.range_err = 1'b0;
  assign err_count     = '0;
`endif

endmodule
